// File: rtl/sseg_scan_driver.sv
// rtl/sseg_scan_driver.sv - multiplexed seven-segment scan driver with dead time and leading-zero blanking
//
// Purpose:
//   Time-multiplexes NUM_DIGITS seven-segment digits. Each digit is selected
//   for REFRESH_DIV clock cycles. The first cycle of every digit slot is dark
//   to suppress ghosting. Segment and anode outputs are active-low and
//   registered.
//
// Parameters:
//   NUM_DIGITS   number of multiplexed digits (1..8)
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//   HEX_MODE     0: codes 10..15 are blank, 1: codes 10..15 show A,b,C,d,E,F
//
// Ports:
//   clk_i          clock, rising edge
//   reset_i        asynchronous active-high reset
//   enable_i       1 = scan runs, 0 = scan frozen and display dark
//   digits_i       4-bit code per digit, digit i at [4i+3:4i]
//   dp_en_i        per-digit decimal point enable
//   blank_i        per-digit force-dark (dp included)
//   lz_suppress_i  1 = blank leading zeros (digit 0 never blanked)
//   sseg_o         active-low segments {dp,g,f,e,d,c,b,a}
//   an_o           active-low one-hot digit select
//   frame_tick_o   one-cycle pulse after each completed scan of all digits

module sseg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int HEX_MODE    = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_en_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    lz_suppress_i,
  output logic [7:0]              sseg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_tick_o
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Scan position
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Registered outputs
  logic [7:0]            sseg_q, sseg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_tick_q, frame_tick_d;

  // Selected-digit attributes
  logic                  cnt_wrap;
  logic [3:0]            sel_code;
  logic                  sel_dp;
  logic                  sel_blank;
  logic                  sel_lz;
  logic [NUM_DIGITS-1:0] an_sel;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    seg = 7'b1111111;
    case (code)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = (HEX_MODE != 0) ? 7'b0001000 : 7'b1111111;
      4'hB: seg = (HEX_MODE != 0) ? 7'b0000011 : 7'b1111111;
      4'hC: seg = (HEX_MODE != 0) ? 7'b1000110 : 7'b1111111;
      4'hD: seg = (HEX_MODE != 0) ? 7'b0100001 : 7'b1111111;
      4'hE: seg = (HEX_MODE != 0) ? 7'b0000110 : 7'b1111111;
      4'hF: seg = (HEX_MODE != 0) ? 7'b0001110 : 7'b1111111;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Refresh counter and scan index; both freeze while disabled
  always_comb begin
    cnt_wrap = (cnt_q == CNT_LAST);
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    if (enable_i) begin
      cnt_d = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
      if (cnt_wrap) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  // Leading-zero mask: walk from the most significant digit down while
  // every digit seen so far is zero. Digit 0 always stays visible.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (digits_i[4*i +: 4] == 4'h0);
      lz_mask[i] = lz_suppress_i & zero_run & (i != 0);
    end
  end

  // Pick the attributes of the digit at idx_q
  always_comb begin
    sel_code  = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    sel_lz    = 1'b0;
    an_sel    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_code  = digits_i[4*i +: 4];
        sel_dp    = dp_en_i[i];
        sel_blank = blank_i[i];
        sel_lz    = lz_mask[i];
        an_sel[i] = 1'b0;
      end
    end
  end

  // Output next-state: dark when disabled or in the dead cycle (cnt==0)
  always_comb begin
    an_d         = '1;
    sseg_d       = 8'hFF;
    frame_tick_d = 1'b0;
    if (enable_i) begin
      // Pulse follows the edge where idx wraps from the last digit to 0
      frame_tick_d = cnt_wrap && (idx_q == IDX_LAST);
      if (cnt_q != '0) begin
        an_d = an_sel;
        if (!sel_blank) begin
          sseg_d = {~sel_dp, sel_lz ? 7'b1111111 : seg_decode(sel_code)};
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      an_q         <= '1;
      sseg_q       <= 8'hFF;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign sseg_o       = sseg_q;
  assign an_o         = an_q;
  assign frame_tick_o = frame_tick_q;

endmodule
